// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer: state encoding,
// buffer geometry, terminator word and instruction field positions.
package program_sequencer_pkg;
   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;
   localparam int INSTR_W = 16;
   localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

   // Instruction layout: {rd_addr, data, op, wr_addr, we}
   localparam int RD_MSB   = 15;
   localparam int RD_LSB   = 12;
   localparam int DATA_MSB = 11;
   localparam int DATA_LSB = 8;
   localparam int OP_MSB   = 7;
   localparam int OP_LSB   = 5;
   localparam int WA_MSB   = 4;
   localparam int WA_LSB   = 1;
   localparam int WE_BIT   = 0;

   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'd0,
      SEQ_RUN    = 2'd1,
      SEQ_PAUSED = 2'd2,
      SEQ_DONE   = 2'd3
   } seq_state_e;
endpackage

// File: rtl/program_sequencer_if.sv
// Control/load/issue bundle between the front panel, the sequencer and the datapath.
interface program_sequencer_if;
   import program_sequencer_pkg::*;
   logic [INSTR_W-1:0] Manual_Instr;
   logic               Load_Valid;
   logic [ADDR_W-1:0]  Load_Addr;
   logic [INSTR_W-1:0] Load_Data;
   logic               Load_Ready;
   logic               Run_Req;
   logic               Step_Req;
   logic               Halt_Req;
   logic [INSTR_W-1:0] Instruction;
   logic               Issue_Valid;
   logic [ADDR_W-1:0]  PC;
   logic [1:0]         Seq_State;
   logic               Done;

   modport master (
      output Manual_Instr, Load_Valid, Load_Addr, Load_Data, Run_Req, Step_Req, Halt_Req,
      input  Load_Ready, Instruction, Issue_Valid, PC, Seq_State, Done
   );
   modport slave (
      input  Manual_Instr, Load_Valid, Load_Addr, Load_Data, Run_Req, Step_Req, Halt_Req,
      output Load_Ready, Instruction, Issue_Valid, PC, Seq_State, Done
   );
endinterface

// File: rtl/program_sequencer_prog_buffer.sv
// Program store: one synchronous write port, one asynchronous read port.
// A same-cycle write to the read address still returns the old word.
module prog_buffer
   import program_sequencer_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [ADDR_W-1:0]  i_waddr,
   input  logic [INSTR_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0]  i_raddr,
   output logic [INSTR_W-1:0] o_rdata
);
   // Contents survive reset; power-up value makes an unloaded program stop at once.
   logic [INSTR_W-1:0] r_mem [DEPTH] = '{default: HALT_WORD};

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/program_sequencer.sv
// Replays a loaded program into the datapath instruction port, with
// run / pause / single-step / halt control and manual pass-through in IDLE.
module program_sequencer
   import program_sequencer_pkg::*;
(
   input  logic CLK_In,
   input  logic Reset_In,
   program_sequencer_if.slave bus
);
   seq_state_e         r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
   logic [INSTR_W-1:0] r_instr, w_instr_nxt;
   logic               r_issue, w_issue_nxt;
   logic               w_try_issue;
   logic               w_load_ready;
   logic               w_we;
   logic [INSTR_W-1:0] w_rdata;

   assign w_load_ready = (r_state != SEQ_RUN);
   assign w_we         = bus.Load_Valid & w_load_ready & ~Reset_In;

   prog_buffer u_buf (
      .i_clk   (CLK_In),
      .i_we    (w_we),
      .i_waddr (bus.Load_Addr),
      .i_wdata (bus.Load_Data),
      .i_raddr (r_pc),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge CLK_In) begin
      if (Reset_In) begin
         r_state <= SEQ_IDLE;
         r_pc    <= '0;
         r_instr <= '0;
         r_issue <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
         r_issue <= w_issue_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      w_issue_nxt = 1'b0;
      w_try_issue = 1'b0;
      // Request priority within each state: Halt > Run > Step.
      unique case (r_state)
         SEQ_IDLE: begin
            w_instr_nxt = bus.Manual_Instr;
            if (bus.Halt_Req) begin
               w_state_nxt = SEQ_IDLE;
            end else if (bus.Run_Req) begin
               w_pc_nxt    = '0;
               w_state_nxt = SEQ_RUN;
            end else if (bus.Step_Req) begin
               w_try_issue = 1'b1;
            end
         end
         SEQ_RUN: begin
            if (bus.Halt_Req) w_state_nxt = SEQ_PAUSED;
            else              w_try_issue = 1'b1;
         end
         SEQ_PAUSED: begin
            if (bus.Halt_Req) begin
               w_state_nxt = SEQ_IDLE;
               w_pc_nxt    = '0;
            end else if (bus.Run_Req) begin
               w_state_nxt = SEQ_RUN;
            end else if (bus.Step_Req) begin
               w_try_issue = 1'b1;
            end
         end
         SEQ_DONE: begin
            if (bus.Halt_Req) begin
               w_state_nxt = SEQ_IDLE;
               w_pc_nxt    = '0;
            end else if (bus.Run_Req) begin
               w_state_nxt = SEQ_RUN;
               w_pc_nxt    = '0;
            end
         end
         default: w_state_nxt = SEQ_IDLE;
      endcase

      // Terminator stops without issuing; the last slot issues then stops.
      if (w_try_issue) begin
         if (w_rdata == HALT_WORD) begin
            w_state_nxt = SEQ_DONE;
         end else begin
            w_instr_nxt = w_rdata;
            w_issue_nxt = 1'b1;
            w_pc_nxt    = r_pc + ADDR_W'(1);
            if (r_pc == ADDR_W'(DEPTH-1)) w_state_nxt = SEQ_DONE;
            else if (r_state != SEQ_RUN)  w_state_nxt = SEQ_PAUSED;
         end
      end
   end

   assign bus.Load_Ready  = w_load_ready;
   assign bus.Instruction = r_instr;
   assign bus.Issue_Valid = r_issue;
   assign bus.PC          = r_pc;
   assign bus.Seq_State   = r_state;
   assign bus.Done        = (r_state == SEQ_DONE);
endmodule

// File: tb/tb_program_sequencer.sv
// Directed scenarios plus randomized control/load traffic, checked against a
// cycle-level behavioural model of the sequencer.
module tb_program_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   program_sequencer_if ifc();

   program_sequencer dut (
      .CLK_In   (clk),
      .Reset_In (rst),
      .bus      (ifc.slave)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: 0=IDLE 1=RUN 2=PAUSED 3=DONE
   logic [15:0] m_mem [16];
   int          m_st, m_pc;
   logic [15:0] m_ins;
   logic        m_iv;
   logic [15:0] exp_w [16];

   logic [24:0] dut_vec;
   assign dut_vec = {ifc.Seq_State, ifc.PC, ifc.Instruction, ifc.Issue_Valid, ifc.Done, ifc.Load_Ready};

   function automatic logic [24:0] m_vec();
      logic [1:0] s;
      logic [3:0] p;
      s = m_st[1:0];
      p = m_pc[3:0];
      return {s, p, m_ins, m_iv, (m_st == 3), (m_st != 1)};
   endfunction

   task automatic model_edge();
      logic [15:0] w;
      bit ld, try_i;
      ld    = ifc.Load_Valid && (m_st != 1) && !rst;
      w     = m_mem[m_pc];
      m_iv  = 1'b0;
      try_i = 0;
      if (rst) begin
         m_st = 0; m_pc = 0; m_ins = 16'h0;
      end else begin
         case (m_st)
            0: begin
               m_ins = ifc.Manual_Instr;
               if (!ifc.Halt_Req && ifc.Run_Req) m_st = 1;
               else if (!ifc.Halt_Req && ifc.Step_Req) try_i = 1;
            end
            1: if (ifc.Halt_Req) m_st = 2; else try_i = 1;
            2: if (ifc.Halt_Req) begin m_st = 0; m_pc = 0; end
               else if (ifc.Run_Req) m_st = 1;
               else if (ifc.Step_Req) try_i = 1;
            default: if (ifc.Halt_Req) begin m_st = 0; m_pc = 0; end
               else if (ifc.Run_Req) begin m_st = 1; m_pc = 0; end
         endcase
         if (try_i) begin
            if (w == 16'h0000) m_st = 3;
            else begin
               m_ins = w; m_iv = 1'b1;
               if (m_pc == 15) begin m_pc = 0; m_st = 3; end
               else begin m_pc++; if (m_st != 1) m_st = 2; end
            end
         end
      end
      if (ld) m_mem[ifc.Load_Addr] = ifc.Load_Data;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      ifc.Run_Req = 0; ifc.Step_Req = 0; ifc.Halt_Req = 0; ifc.Load_Valid = 0;
   endtask

   task automatic load(input logic [3:0] a, input logic [15:0] d);
      ifc.Load_Valid = 1; ifc.Load_Addr = a; ifc.Load_Data = d;
      tick();
   endtask

   task automatic test_reset();
      rst = 1; ifc.Load_Valid = 1; ifc.Load_Addr = 4'd5; ifc.Load_Data = 16'h1234; ifc.Run_Req = 1;
      tick();
      rst = 0;
      checks++;
      if (dut_vec !== {2'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL reset_state: got %h want %h", dut_vec, {2'd0, 4'd0, 16'h0000, 3'b001});
      end
   endtask

   task automatic test_manual();
      ifc.Manual_Instr = 16'h0A03;
      tick(); tick();
      checks++;
      if (ifc.Instruction !== 16'h0A03 || ifc.Issue_Valid !== 1'b0 || ifc.Seq_State !== 2'd0) begin
         errors++; $display("FAIL manual_fwd: got instr=%h iv=%b st=%0d want 0a03/0/0", ifc.Instruction, ifc.Issue_Valid, ifc.Seq_State);
      end
   endtask

   task automatic test_run_short();
      load(4'd0, 16'h0310); load(4'd1, 16'h0523); load(4'd2, 16'h0000);
      ifc.Run_Req = 1; tick();
      checks++;
      if (ifc.Seq_State !== 2'd1 || ifc.Issue_Valid !== 1'b0) begin
         errors++; $display("FAIL run_start: got st=%0d iv=%b want 1/0", ifc.Seq_State, ifc.Issue_Valid);
      end
      tick();
      checks++;
      if (ifc.Instruction !== 16'h0310 || ifc.Issue_Valid !== 1'b1) begin
         errors++; $display("FAIL run_issue0: got %h iv=%b want 0310/1", ifc.Instruction, ifc.Issue_Valid);
      end
      tick();
      checks++;
      if (ifc.Instruction !== 16'h0523 || ifc.Issue_Valid !== 1'b1) begin
         errors++; $display("FAIL run_issue1: got %h iv=%b want 0523/1", ifc.Instruction, ifc.Issue_Valid);
      end
      tick();
      checks++;
      if (dut_vec !== {2'd3, 4'd2, 16'h0523, 1'b0, 1'b1, 1'b1}) begin
         errors++; $display("FAIL run_done: got %h want %h", dut_vec, {2'd3, 4'd2, 16'h0523, 3'b011});
      end
      ifc.Halt_Req = 1; tick();
   endtask

   task automatic test_full_wrap();
      for (int i = 0; i < 16; i++) begin
         exp_w[i] = 16'($urandom_range(1, 16'hFFFF));
         load(4'(i), exp_w[i]);
      end
      ifc.Run_Req = 1; tick();
      for (int i = 0; i < 16; i++) begin
         if (i == 5) begin ifc.Load_Valid = 1; ifc.Load_Addr = 4'd1; ifc.Load_Data = 16'h0000; end
         tick();
         checks++;
         if (ifc.Instruction !== exp_w[i] || ifc.Issue_Valid !== 1'b1 || (i < 15 && ifc.Load_Ready !== 1'b0)) begin
            errors++; $display("FAIL wrap_issue%0d: got %h iv=%b rdy=%b want %h/1", i, ifc.Instruction, ifc.Issue_Valid, ifc.Load_Ready, exp_w[i]);
         end
      end
      checks++;
      if (ifc.Seq_State !== 2'd3 || ifc.PC !== 4'd0) begin
         errors++; $display("FAIL wrap_done: got st=%0d pc=%0d want 3/0", ifc.Seq_State, ifc.PC);
      end
      ifc.Halt_Req = 1; tick();
      ifc.Step_Req = 1; tick();
      ifc.Step_Req = 1; tick();
      checks++;
      if (ifc.Instruction !== exp_w[1] || ifc.Issue_Valid !== 1'b1) begin
         errors++; $display("FAIL run_load_blocked: got %h want %h", ifc.Instruction, exp_w[1]);
      end
      ifc.Halt_Req = 1; tick();
   endtask

   task automatic test_halt_step();
      ifc.Run_Req = 1; tick();
      tick(); tick();
      ifc.Halt_Req = 1; tick();
      checks++;
      if (dut_vec !== {2'd2, 4'd2, exp_w[1], 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL halt_pause: got %h want %h", dut_vec, {2'd2, 4'd2, exp_w[1], 3'b001});
      end
      for (int k = 2; k < 4; k++) begin
         ifc.Step_Req = 1; tick();
         checks++;
         if (ifc.Instruction !== exp_w[k] || ifc.Issue_Valid !== 1'b1 || ifc.Seq_State !== 2'd2) begin
            errors++; $display("FAIL step%0d: got %h iv=%b st=%0d want %h/1/2", k, ifc.Instruction, ifc.Issue_Valid, ifc.Seq_State, exp_w[k]);
         end
         tick();
         checks++;
         if (ifc.Issue_Valid !== 1'b0 || ifc.Instruction !== exp_w[k]) begin
            errors++; $display("FAIL step%0d_hold: got %h iv=%b want %h/0", k, ifc.Instruction, ifc.Issue_Valid, exp_w[k]);
         end
      end
      ifc.Run_Req = 1; tick();
      checks++;
      if (ifc.PC !== 4'd4 || ifc.Seq_State !== 2'd1) begin
         errors++; $display("FAIL resume_pc: got pc=%0d st=%0d want 4/1", ifc.PC, ifc.Seq_State);
      end
      tick();
      checks++;
      if (ifc.Instruction !== exp_w[4]) begin
         errors++; $display("FAIL resume_issue: got %h want %h", ifc.Instruction, exp_w[4]);
      end
   endtask

   task automatic test_priority();
      ifc.Halt_Req = 1; ifc.Run_Req = 1; tick();
      checks++;
      if (ifc.Seq_State !== 2'd2 || ifc.Issue_Valid !== 1'b0) begin
         errors++; $display("FAIL halt_over_run: got st=%0d iv=%b want 2/0", ifc.Seq_State, ifc.Issue_Valid);
      end
      ifc.Run_Req = 1; tick(); tick();
      rst = 1; tick(); rst = 0;
      checks++;
      if (dut_vec !== {2'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL reset_midrun: got %h want %h", dut_vec, {2'd0, 4'd0, 16'h0000, 3'b001});
      end
      ifc.Step_Req = 1; tick();
      checks++;
      if (ifc.Instruction !== exp_w[0] || ifc.Issue_Valid !== 1'b1 || ifc.PC !== 4'd1) begin
         errors++; $display("FAIL buf_retained: got %h iv=%b pc=%0d want %h/1/1", ifc.Instruction, ifc.Issue_Valid, ifc.PC, exp_w[0]);
      end
      ifc.Halt_Req = 1; tick();
   endtask

   task automatic test_step_halt_word();
      load(4'd0, 16'h0000);
      ifc.Step_Req = 1; tick();
      checks++;
      if (ifc.Seq_State !== 2'd3 || ifc.Done !== 1'b1 || ifc.Issue_Valid !== 1'b0) begin
         errors++; $display("FAIL step_halt_word: got st=%0d done=%b iv=%b want 3/1/0", ifc.Seq_State, ifc.Done, ifc.Issue_Valid);
      end
      ifc.Halt_Req = 1; tick();
      ifc.Manual_Instr = 16'h5A5A; tick();
      checks++;
      if (ifc.Seq_State !== 2'd0 || ifc.Instruction !== 16'h5A5A) begin
         errors++; $display("FAIL idle_return: got st=%0d instr=%h want 0/5a5a", ifc.Seq_State, ifc.Instruction);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         ifc.Manual_Instr = 16'($urandom);
         ifc.Run_Req  = ($urandom_range(0, 7) == 0);
         ifc.Step_Req = ($urandom_range(0, 4) == 0);
         ifc.Halt_Req = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 2) == 0) begin
            ifc.Load_Valid = 1;
            ifc.Load_Addr  = 4'($urandom);
            ifc.Load_Data  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         end
         rst = ($urandom_range(0, 99) == 0);
         tick();
         rst = 0;
         checks++;
         if (dut_vec !== m_vec()) begin
            errors++; $display("FAIL random_cycle%0d: got %h want %h", n, dut_vec, m_vec());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
      m_st = 0; m_pc = 0; m_ins = 16'h0; m_iv = 1'b0;
      ifc.Manual_Instr = 16'h0; ifc.Load_Valid = 0; ifc.Load_Addr = 4'd0; ifc.Load_Data = 16'h0;
      ifc.Run_Req = 0; ifc.Step_Req = 0; ifc.Halt_Req = 0;
      #2;
      test_reset();
      test_manual();
      test_run_short();
      test_full_wrap();
      test_halt_step();
      test_priority();
      test_step_halt_word();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
